// File: rtl/job_dispatcher_pkg.sv
// job_dispatcher_pkg: FSM encoding, opcode set and descriptor field layout shared by the dispatcher.
package job_dispatcher_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, CHECK, ISSUE} state_t;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_COPY  = 8'h03;
  localparam logic [7:0] OP_FILL  = 8'h04;
  localparam int OPC_LSB = 40;
  localparam int OPC_MSB = 47;
  localparam int LEN_LSB = 48;
  localparam int LEN_MSB = 63;
  function automatic logic malformed(input logic [63:0] d);
    logic [7:0] op;
    logic [15:0] len;
    op = d[OPC_MSB:OPC_LSB];
    len = d[LEN_MSB:LEN_LSB];
    return op < OP_LOAD || op > OP_FILL || len == '0;
  endfunction
endpackage

// File: rtl/job_credit_counter.sv
// job_credit_counter: issued-minus-done credit count with a sticky underflow flag.
module job_credit_counter #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 err_underflow
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      err_underflow <= 1'b0;
    end else if (inc && !dec) begin
      count <= count + 1'b1;
    end else if (dec && !inc) begin
      if (count == '0) err_underflow <= 1'b1;
      else count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/job_dispatcher.sv
// job_dispatcher: fetches descriptors from a job FIFO, drops malformed ones and offers the rest
// to an engine under a credit limit on issued-but-not-done jobs.
module job_dispatcher
  import job_dispatcher_pkg::*;
#(
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dispatch_en,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  job_valid,
  input  logic                  job_ready,
  output logic [DATA_WIDTH-1:0] job_desc,
  input  logic                  job_done,
  output logic [CNT_WIDTH-1:0]  outstanding,
  output logic                  busy,
  output logic                  drop_pulse,
  output logic                  err_underflow,
  output logic [15:0]           issued_count
);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] desc;
  logic accept, bad;
  assign bad      = malformed(desc[63:0]);
  assign accept   = job_valid && job_ready;
  assign job_desc = desc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (dispatch_en && !fifo_empty && outstanding < MAX_CNT) ? FETCH : IDLE;
      FETCH:   state_nx = LATCH;
      LATCH:   state_nx = CHECK;
      CHECK:   state_nx = bad ? IDLE : ISSUE;
      ISSUE:   state_nx = accept ? IDLE : ISSUE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    fifo_rd_en = state == FETCH;
    job_valid  = state == ISSUE;
    drop_pulse = state == CHECK && bad;
    busy       = state != IDLE || outstanding != '0;
  end
  // Read data is valid the cycle after the pop, which is the LATCH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) desc <= '0;
    else if (state == LATCH) desc <= fifo_rd_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) issued_count <= '0;
    else if (accept) issued_count <= issued_count + 1'b1;
  end
  job_credit_counter #(.CNT_WIDTH(CNT_WIDTH)) u_credit (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc           (accept),
    .dec           (job_done),
    .count         (outstanding),
    .err_underflow (err_underflow)
  );
endmodule

// File: tb/tb_job_dispatcher.sv
// tb_job_dispatcher: randomized and directed checks of job_dispatcher against a transaction-level model.
module tb_job_dispatcher;
  localparam int DW = 128;
  logic clk = 1'b0, rst_n = 1'b0, dispatch_en = 1'b0, fifo_empty = 1'b1;
  logic job_ready = 1'b0, job_done = 1'b0;
  logic fifo_rd_en, job_valid, busy, drop_pulse, err_underflow;
  logic [DW-1:0] fifo_rd_data = '0, job_desc;
  logic [2:0] outstanding;
  logic [15:0] issued_count;
  always #5 clk = ~clk;
  job_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .dispatch_en(dispatch_en), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .job_valid(job_valid),
    .job_ready(job_ready), .job_desc(job_desc), .job_done(job_done), .outstanding(outstanding),
    .busy(busy), .drop_pulse(drop_pulse), .err_underflow(err_underflow), .issued_count(issued_count)
  );
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] fifo_q[$], exp_q[$];
  int m_out = 0, m_issued = 0, drops = 0, exp_drops = 0, rd_cnt = 0;
  bit m_err = 0, acc_p = 0, dn_p = 0, val_p = 0, rd_p = 0;
  logic [DW-1:0] desc_p = '0;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit is_bad(input logic [DW-1:0] d);
    return d[47:40] == 8'h00 || d[47:40] > 8'h04 || d[63:48] == 16'h0;
  endfunction
  function automatic logic [DW-1:0] mk(input logic [7:0] op, input logic [15:0] len, input logic [31:0] id);
    logic [DW-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[63:48] = len;
    d[47:40] = op;
    d[31:0] = id;
    return d;
  endfunction
  task automatic push(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    if (is_bad(d)) exp_drops++;
    else exp_q.push_back(d);
    fifo_empty = 1'b0;
  endtask
  // One clock: apply last cycle's handshake/done to the model, check, serve the FIFO, drive inputs.
  task automatic step(input bit rdy, input bit dn, input bit en);
    @(negedge clk);
    if (acc_p && !dn_p) m_out++;
    else if (dn_p && !acc_p) begin
      if (m_out == 0) m_err = 1;
      else m_out--;
    end
    if (acc_p) m_issued = (m_issued + 1) % 65536;
    chk("outstanding", outstanding, m_out);
    chk("issued_count", issued_count, m_issued);
    chk("err_underflow", err_underflow, m_err);
    if (m_out != 0 || job_valid) chk("busy", busy, 1);
    if (val_p && !acc_p) begin
      chk("valid_hold", job_valid, 1);
      chk("desc_hold", job_desc, desc_p);
    end
    if (drop_pulse) drops++;
    if (fifo_rd_en) begin
      rd_cnt++;
      chk("rd_single", rd_p, 0);
      chk("pop_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
      fifo_empty = fifo_q.size() == 0;
    end
    rd_p = fifo_rd_en;
    job_ready = rdy;
    job_done = dn;
    dispatch_en = en;
    acc_p = job_valid && rdy;
    dn_p = dn;
    val_p = job_valid;
    desc_p = job_desc;
    if (acc_p) begin
      chk("accept_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("job_desc_order", job_desc, exp_q.pop_front());
    end
  endtask
  task automatic run(input int n, input bit rdy, input bit dn, input bit en);
    for (int k = 0; k < n; k++) step(rdy, dn, en);
  endtask
  task automatic wait_valid(input bit en);
    int k;
    k = 0;
    while (!job_valid && k < 50) begin
      step(0, 0, en);
      k++;
    end
    chk("wait_valid", job_valid, 1);
  endtask
  task automatic drain();
    int k;
    k = 0;
    while ((m_out != 0 || fifo_q.size() != 0 || busy) && k < 120) begin
      step(1, k % 2 == 0 && m_out != 0, 1);
      k++;
    end
    chk("drained", m_out, 0);
  endtask
  initial begin
    int r0, i0, d0, o0;
    logic [DW-1:0] d;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", job_valid, 0);
    chk("rst_drop", drop_pulse, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_desc", job_desc, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) push(mk(8'h02, 16'h0010, i));
    r0 = rd_cnt;
    run(25, 1, 0, 1);
    chk("three_issued", issued_count, 3);
    chk("three_fetches", rd_cnt - r0, 3);
    drain();
    d = mk(8'h03, 16'h0008, 100);
    push(d);
    wait_valid(1);
    i0 = m_issued;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      chk("bp_valid", job_valid, 1);
      chk("bp_desc", job_desc, d);
    end
    step(1, 0, 1);
    step(1, 0, 1);
    chk("bp_accept", issued_count, (i0 + 1) % 65536);
    drain();
    for (int i = 0; i < 6; i++) push(mk(8'h01, 16'h0004, 10 + i));
    run(60, 1, 0, 1);
    chk("credit_cap", outstanding, 4);
    r0 = rd_cnt;
    run(20, 1, 0, 1);
    chk("credit_no_fetch", rd_cnt - r0, 0);
    chk("credit_left", fifo_q.size(), 2);
    step(1, 1, 1);
    run(10, 1, 0, 1);
    chk("credit_fifth_fetch", rd_cnt - r0, 1);
    chk("credit_left2", fifo_q.size(), 1);
    chk("credit_refill", outstanding, 4);
    drain();
    d0 = drops;
    i0 = m_issued;
    push(mk(8'h07, 16'h0010, 200));
    push(mk(8'h02, 16'h0000, 201));
    push(mk(8'h01, 16'h0004, 202));
    run(30, 1, 0, 1);
    chk("drop_count", drops - d0, 2);
    chk("malformed_issue", issued_count, (i0 + 1) % 65536);
    drain();
    step(1, 1, 1);
    step(1, 0, 1);
    chk("underflow_set", err_underflow, 1);
    chk("underflow_cnt", outstanding, 0);
    push(mk(8'h04, 16'h0020, 210));
    run(12, 1, 0, 1);
    push(mk(8'h04, 16'h0020, 211));
    wait_valid(1);
    o0 = m_out;
    step(1, 1, 1);
    step(1, 0, 1);
    chk("acc_done_same", outstanding, o0);
    drain();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8)
        push(mk(8'($urandom_range(0, 6)), ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom), $urandom));
      step($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0);
    end
    drain();
    chk("rand_all_issued", exp_q.size(), 0);
    chk("rand_drops", drops, exp_drops);
    push(mk(8'h04, 16'h0020, 300));
    wait_valid(1);
    chk("pre_rst_issued_nz", issued_count != 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", job_valid, 0);
    chk("arst_out", outstanding, 0);
    chk("arst_issued", issued_count, 0);
    fifo_q.delete();
    exp_q.delete();
    push(mk(8'h02, 16'h0010, 301));
    dispatch_en = 1'b1;
    job_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_fetch", fifo_rd_en, 0);
    end
    m_out = 0; m_issued = 0; m_err = 0;
    acc_p = 0; dn_p = 0; val_p = 0; rd_p = 0;
    rst_n = 1'b1;
    run(15, 1, 0, 1);
    chk("post_rst_issue", issued_count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
